// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the shared UART transmit arbiter.
// master = requesters plus UART model, slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [2*NREQ-1:0] req_baud;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   nak;
  logic              busy;
  logic [OW-1:0]     owner;

  logic [7:0]        uart_din;
  logic              uart_run;
  logic              uart_s1;
  logic              uart_s0;
  logic              uart_done;
  logic              uart_err;

  modport master (
    output req, req_data, req_baud, uart_done, uart_err,
    input  ack, nak, busy, owner, uart_din, uart_run, uart_s1, uart_s0
  );

  modport slave (
    input  req, req_data, req_baud, uart_done, uart_err,
    output ack, nak, busy, owner, uart_din, uart_run, uart_s1, uart_s0
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters; grant to uart_run is 1+SETUP_CYCLES.
// Requesters hold req until their ack/nak pulse; SETUP_CYCLES must be at least 1.
module uart_tx_arbiter #(
  parameter int NREQ           = 4,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk_in,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus
);

  localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int OW1 = OW + 1;
  localparam int SW  = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LAUNCH,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   last_grant_q;
  logic [7:0]      din_q;
  logic [1:0]      baud_q;
  logic [SW-1:0]   setup_cnt;
  logic [TW-1:0]   wait_cnt;
  logic            ok_q;
  logic            ok_nxt;

  logic            grant_vld;
  logic [OW-1:0]   grant_idx;
  logic [OW1-1:0]  cand_sum;
  logic [OW-1:0]   cand;
  logic [7:0]      sel_data;
  logic [1:0]      sel_baud;
  logic [NREQ-1:0] owner_onehot;

  logic [NREQ-1:0] ack_c;
  logic [NREQ-1:0] nak_c;
  logic            run_c;
  logic            busy_c;
  logic            grant_c;

  // Search starts just past the last winner so every requester is served within NREQ grants.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_sum = {1'b0, last_grant_q} + OW1'(k);
      if (cand_sum >= OW1'(NREQ)) begin
        cand_sum = cand_sum - OW1'(NREQ);
      end
      cand = cand_sum[OW-1:0];
      if (!grant_vld && bus.req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_baud = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == OW'(i)) begin
        sel_data = bus.req_data[i*8 +: 8];
        sel_baud = bus.req_baud[i*2 +: 2];
      end
    end
  end

  always_comb begin
    owner_onehot          = '0;
    owner_onehot[owner_q] = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ok_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      ok_q  <= ok_nxt;
    end
  end

  // Transfer context is captured only at grant, so later req_data/req_baud edits cannot leak in.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      owner_q      <= '0;
      last_grant_q <= OW'(NREQ - 1);
      din_q        <= '0;
      baud_q       <= '0;
      setup_cnt    <= '0;
      wait_cnt     <= '0;
    end else begin
      if (grant_c) begin
        owner_q <= grant_idx;
        din_q   <= sel_data;
        baud_q  <= sel_baud;
      end
      if (state == S_SETUP) begin
        setup_cnt <= setup_cnt + 1'b1;
      end else begin
        setup_cnt <= '0;
      end
      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (state == S_FINISH) begin
        last_grant_q <= owner_q;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ok_nxt    = ok_q;
    grant_c   = 1'b0;
    run_c     = 1'b0;
    busy_c    = 1'b1;
    ack_c     = '0;
    nak_c     = '0;
    case (state)
      S_IDLE: begin
        busy_c = 1'b0;
        if (grant_vld) begin
          grant_c   = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (setup_cnt == SW'(SETUP_CYCLES - 1)) begin
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        run_c     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // An error wins over a simultaneous done.
        if (bus.uart_err) begin
          ok_nxt    = 1'b0;
          state_nxt = S_FINISH;
        end else if (bus.uart_done) begin
          ok_nxt    = 1'b1;
          state_nxt = S_FINISH;
        end else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          ok_nxt    = 1'b0;
          state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        if (ok_q) begin
          ack_c = owner_onehot;
        end else begin
          nak_c = owner_onehot;
        end
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.ack      = ack_c;
  assign bus.nak      = nak_c;
  assign bus.busy     = busy_c;
  assign bus.owner    = owner_q;
  assign bus.uart_din = din_q;
  assign bus.uart_run = run_c;
  assign bus.uart_s1  = baud_q[1];
  assign bus.uart_s0  = baud_q[0];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: latency, round-robin order, error priority, timeout and mid-transfer reset.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n;
  int   bad;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(4)) bus ();

  uart_tx_arbiter #(
    .NREQ(4),
    .SETUP_CYCLES(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_in(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Counts negedges until uart_run is seen, bounded so a stuck DUT cannot hang the run.
  task automatic wait_run(output int cycles);
    cycles = 0;
    while (!bus.uart_run && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req       = '0;
    bus.req_data  = '0;
    bus.req_baud  = '0;
    bus.uart_done = 1'b0;
    bus.uart_err  = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_run",   32'(bus.uart_run), 0);
    chk("rst_din",   32'(bus.uart_din), 0);
    chk("rst_baud",  32'({bus.uart_s1, bus.uart_s0}), 0);
    chk("rst_acknak", 32'({bus.ack, bus.nak}), 0);
    rst_n = 1'b1;

    // Single transfer: cycle 0 request, run at 3, done at 10, ack at 11, idle at 12
    bus.req      = 4'b0001;
    bus.req_data = 32'h0000_00A5;
    bus.req_baud = 8'b0000_0011;
    @(negedge clk);
    chk("t1_din_c1",  32'(bus.uart_din), 32'hA5);
    chk("t1_baud_c1", 32'({bus.uart_s1, bus.uart_s0}), 3);
    chk("t1_busy_c1", 32'(bus.busy), 1);
    chk("t1_run_c1",  32'(bus.uart_run), 0);
    bus.req_data = 32'h0000_0000;
    bus.req_baud = 8'b0000_0000;
    @(negedge clk);
    chk("t1_run_c2", 32'(bus.uart_run), 0);
    @(negedge clk);
    chk("t1_run_c3", 32'(bus.uart_run), 1);
    chk("t1_din_hold", 32'(bus.uart_din), 32'hA5);
    chk("t1_baud_hold", 32'({bus.uart_s1, bus.uart_s0}), 3);
    bad = 0;
    repeat (7) begin
      @(negedge clk);
      if (bus.uart_run || bus.ack != 0 || bus.nak != 0) bad++;
    end
    chk("t1_wait_quiet", 32'(bad), 0);
    bus.uart_done = 1'b1;
    @(negedge clk);
    bus.uart_done = 1'b0;
    chk("t1_ack_c11", 32'(bus.ack), 32'b0001);
    chk("t1_nak_c11", 32'(bus.nak), 0);
    chk("t1_busy_c11", 32'(bus.busy), 1);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("t1_busy_c12", 32'(bus.busy), 0);
    chk("t1_ack_c12", 32'(bus.ack), 0);

    // Round robin with all requesters held
    do_reset();
    bus.req      = 4'b1111;
    bus.req_data = 32'h1312_1110;
    bus.req_baud = 8'b1110_0100;
    wait_run(n);
    chk("rr_first_lat", 32'(n), 3);
    for (int i = 0; i < 5; i++) begin
      logic [1:0] exp_o;
      exp_o = 2'(i % 4);
      chk($sformatf("rr_owner%0d", i), 32'(bus.owner), 32'(exp_o));
      chk($sformatf("rr_din%0d", i), 32'(bus.uart_din), 32'h10 + 32'(exp_o));
      chk($sformatf("rr_baud%0d", i), 32'({bus.uart_s1, bus.uart_s0}), 32'(exp_o));
      repeat (5) @(negedge clk);
      bus.uart_done = 1'b1;
      @(negedge clk);
      bus.uart_done = 1'b0;
      chk($sformatf("rr_ack%0d", i), 32'(bus.ack), 32'(4'b0001 << exp_o));
      chk($sformatf("rr_nak%0d", i), 32'(bus.nak), 0);
      if (i == 4) bus.req = 4'b0000;
      @(negedge clk);
      chk($sformatf("rr_ack_once%0d", i), 32'(bus.ack), 0);
      if (i < 4) begin
        wait_run(n);
        chk($sformatf("rr_gap%0d", i), 32'(n), 3);
      end
    end
    @(negedge clk);
    chk("rr_idle", 32'(bus.busy), 0);

    // done outside WAIT is ignored; done+err together gives nak
    bus.req      = 4'b0010;
    bus.req_data = 32'h0000_3C00;
    bus.req_baud = 8'b0000_0100;
    @(negedge clk);
    bus.uart_done = 1'b1;
    @(negedge clk);
    bus.uart_done = 1'b0;
    chk("de_setup_noack", 32'({bus.ack, bus.nak}), 0);
    wait_run(n);
    chk("de_lat", 32'(n), 1);
    chk("de_owner", 32'(bus.owner), 1);
    chk("de_din", 32'(bus.uart_din), 32'h3C);
    chk("de_baud", 32'({bus.uart_s1, bus.uart_s0}), 1);
    repeat (2) @(negedge clk);
    bus.uart_done = 1'b1;
    bus.uart_err  = 1'b1;
    @(negedge clk);
    bus.uart_done = 1'b0;
    bus.uart_err  = 1'b0;
    chk("de_nak", 32'(bus.nak), 32'b0010);
    chk("de_ack", 32'(bus.ack), 0);
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);
    chk("de_idle", 32'(bus.busy), 0);

    // Timeout after 16 WAIT cycles
    bus.req      = 4'b1000;
    bus.req_data = 32'h7E00_0000;
    wait_run(n);
    chk("to_owner", 32'(bus.owner), 3);
    bad = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus.ack != 0 || bus.nak != 0 || !bus.busy) bad++;
    end
    chk("to_no_early", 32'(bad), 0);
    @(negedge clk);
    chk("to_nak", 32'(bus.nak), 32'b1000);
    chk("to_ack", 32'(bus.ack), 0);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("to_idle", 32'(bus.busy), 0);
    chk("to_nak_once", 32'(bus.nak), 0);

    // Reset during WAIT aborts silently; requester 0 has priority afterwards
    bus.req      = 4'b0100;
    bus.req_data = 32'h0055_0000;
    bus.req_baud = 8'b0010_0000;
    wait_run(n);
    chk("mr_owner", 32'(bus.owner), 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_acknak", 32'({bus.ack, bus.nak}), 0);
    chk("mr_busy",  32'(bus.busy), 0);
    chk("mr_owner0", 32'(bus.owner), 0);
    chk("mr_din",   32'(bus.uart_din), 0);
    chk("mr_baud",  32'({bus.uart_s1, bus.uart_s0}), 0);
    chk("mr_run",   32'(bus.uart_run), 0);
    rst_n        = 1'b1;
    bus.req      = 4'b0101;
    bus.req_data = 32'h0055_00C3;
    bad = 0;
    n = 0;
    while (!bus.uart_run && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.ack != 0 || bus.nak != 0) bad++;
    end
    chk("mr_no_pulse", 32'(bad), 0);
    chk("mr_lat", 32'(n), 3);
    chk("mr_first", 32'(bus.owner), 0);
    chk("mr_first_din", 32'(bus.uart_din), 32'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing one UART.
REQ-002 Parameter SETUP_CYCLES, default 2, SHALL set the cycles baud-select is held before launch.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the maximum WAIT cycles before abort.
REQ-004 clk_in  input  1  SHALL be the single clock; all state is rising-edge.
REQ-005 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 req  input  NREQ  SHALL carry per-requester transmit requests, held high until ack or nak.
REQ-007 req_data  input  8*NREQ  SHALL carry the byte for requester i at [8i+7:8i].
REQ-008 req_baud  input  2*NREQ  SHALL carry {s1,s0} for requester i at [2i+1:2i].
REQ-009 ack  output  NREQ  SHALL pulse one cycle on the owner's bit at successful completion.
REQ-010 nak  output  NREQ  SHALL pulse one cycle on the owner's bit at failed completion.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.
REQ-012 owner  output  $clog2(NREQ)  SHALL give the index of the current or last granted requester.
REQ-013 uart_din  output  8  SHALL drive the UART data input.
REQ-014 uart_run  output  1  SHALL drive the UART start strobe.
REQ-015 uart_s1, uart_s0  output  1 each  SHALL drive the UART baud select.
REQ-016 uart_done  input  1  SHALL carry the UART completion strobe.
REQ-017 uart_err  input  1  SHALL carry the UART error strobe.

Function
REQ-018 The FSM SHALL have the states IDLE, SETUP, LAUNCH, WAIT and FINISH.
REQ-019 In IDLE with req != 0, the block SHALL grant round-robin: search from last_grant+1 mod NREQ upward, first set bit wins.
REQ-020 On grant, owner, uart_din and {uart_s1,uart_s0} SHALL load from the winner's slices at the same edge, and the FSM SHALL enter SETUP.
REQ-021 SETUP SHALL last exactly SETUP_CYCLES cycles, then enter LAUNCH.
REQ-022 uart_run SHALL be high for exactly the one LAUNCH cycle, then the FSM SHALL enter WAIT.
REQ-023 uart_din and baud select SHALL stay stable from grant until return to IDLE.
REQ-024 uart_done and uart_err SHALL be ignored outside WAIT.
REQ-025 In WAIT, uart_done SHALL record success and uart_err SHALL record failure; the FSM SHALL then enter FINISH.
REQ-026 If uart_done and uart_err assert in the same cycle, the result SHALL be failure.
REQ-027 A WAIT cycle counter SHALL start at 0; on reaching TIMEOUT_CYCLES-1 without done or err, the result SHALL be failure and the FSM SHALL enter FINISH.
REQ-028 FINISH SHALL pulse ack[owner] or nak[owner] (never both), set last_grant=owner, and return to IDLE the next cycle.
REQ-029 Deassertion of req[owner] mid-transfer SHALL NOT abort the transfer; ack or nak SHALL still pulse.
REQ-030 Changes to req_data or req_baud after grant SHALL have no effect on the current transfer.
REQ-031 Latency: req sampled in IDLE at cycle T -> uart_run high at T+1+SETUP_CYCLES; uart_done in cycle D -> ack in D+1; next grant no earlier than D+2.

Reset
REQ-032 With rst_n low at an edge, the following SHALL clear: FSM=IDLE, uart_run=0, uart_din=0, uart_s1=uart_s0=0, ack=nak=0, busy=0, owner=0, last_grant=NREQ-1, counters=0.
REQ-033 Reset mid-transfer SHALL abort without any ack or nak pulse; requester 0 SHALL have first priority afterwards.

Verification
REQ-034 req=0001, data0=0xA5, baud0=11 -> uart_din=0xA5, s1s0=11 from cycle 1; run high at cycle 3; done at 10 -> ack=0001 at 11, busy low at 12.
REQ-035 req=1111 held, done returned 5 cycles after each run -> grant order 0,1,2,3,0; each ack one cycle; no gap >2 cycles between FINISH and the next SETUP.
REQ-036 uart_done and uart_err high together in WAIT -> nak[owner] pulse, ack stays 0.
REQ-037 TIMEOUT_CYCLES=16, no done -> nak[owner] in FINISH after 16 WAIT cycles, then IDLE.
REQ-038 rst_n low during WAIT with req=0100 -> no ack or nak, all outputs at reset values; req=0101 after reset -> requester 0 granted first.
